// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the regfile write port between ALU and MEM writeback; optional pending-write scoreboard under `WB_SCOREBOARD_EN.
// Latency: an accepted write drives rd_sel/rd_data on the following cycle.
// Backpressure: the losing requester sees ready=0 and holds rd/data; both readies are 0 while reset is high.
module regfile_wb_arbiter #(
   parameter int XLEN       = 32,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   output logic            alu_ready,
   input  logic            mem_valid,
   input  logic [4:0]      mem_rd,
   input  logic [XLEN-1:0] mem_data,
   output logic            mem_ready,
   output logic [4:0]      rd_sel,
   output logic [XLEN-1:0] rd_data,
   input  logic            iss_valid,
   input  logic [4:0]      iss_rd,
   input  logic [4:0]      rs1_sel,
   input  logic [4:0]      rs2_sel,
   output logic            rs1_busy,
   output logic            rs2_busy
);

   typedef enum logic {WIN_ALU = 1'b0, WIN_MEM = 1'b1} winner_t;

   winner_t         last_winner, last_winner_nxt;
   logic            alu_gnt, mem_gnt;
   logic            alu_xfer, mem_xfer;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;

   // Tie-break state only moves when both requesters contend.
   always_comb begin
      alu_gnt         = 1'b0;
      mem_gnt         = 1'b0;
      last_winner_nxt = last_winner;
      if (alu_valid && mem_valid) begin
         if (FIXED_PRIO || last_winner == WIN_MEM) begin
            alu_gnt         = 1'b1;
            last_winner_nxt = WIN_ALU;
         end else begin
            mem_gnt         = 1'b1;
            last_winner_nxt = WIN_MEM;
         end
      end else begin
         alu_gnt = alu_valid;
         mem_gnt = mem_valid;
      end
   end

   assign alu_ready = alu_gnt && !reset;
   assign mem_ready = mem_gnt && !reset;
   assign alu_xfer  = alu_valid && alu_ready;
   assign mem_xfer  = mem_valid && mem_ready;

   always_comb begin
      wb_rd   = '0;
      wb_data = '0;
      if (alu_xfer) begin
         wb_rd   = alu_rd;
         wb_data = alu_data;
      end else if (mem_xfer) begin
         wb_rd   = mem_rd;
         wb_data = mem_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_winner <= WIN_MEM;
         rd_sel      <= '0;
         rd_data     <= '0;
      end else begin
         last_winner <= last_winner_nxt;
         rd_sel      <= wb_rd;
         rd_data     <= wb_data;
      end
   end

`ifdef WB_SCOREBOARD_EN
   logic [31:0] pending, set_mask, clr_mask;

   // Clear on the edge that registers the write; a same-edge issue re-sets it.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (iss_valid && iss_rd != 5'd0) set_mask[iss_rd] = 1'b1;
      if (alu_xfer || mem_xfer)        clr_mask[wb_rd]  = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) pending <= '0;
      else       pending <= (pending & ~clr_mask) | set_mask;
   end

   assign rs1_busy = pending[rs1_sel];
   assign rs2_busy = pending[rs2_sel];

   always_ff @(posedge clk) begin
      if (!reset && iss_valid && iss_rd != 5'd0)
         assert (!pending[iss_rd]) else $error("second writer issued to busy rd %0d", iss_rd);
   end
`else
   logic unused_iss;
   assign unused_iss = ^{iss_valid, iss_rd};
   assign rs1_busy   = 1'b0;
   assign rs2_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios, then random traffic against a queue-based reference model.
// Two instances share stimulus: round-robin (dut) and fixed-priority (dut_fp, never issues).
module tb_regfile_wb_arbiter;
   localparam int XLEN = 32;
`ifdef WB_SCOREBOARD_EN
   localparam bit SB_EN = 1'b1;
`else
   localparam bit SB_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset, alu_valid, mem_valid, iss_valid;
   logic [4:0]      alu_rd, mem_rd, iss_rd, rs1_sel, rs2_sel;
   logic [XLEN-1:0] alu_data, mem_data;
   logic            alu_ready, mem_ready, rs1_busy, rs2_busy;
   logic [4:0]      rd_sel;
   logic [XLEN-1:0] rd_data;
   logic            fp_alu_ready, fp_mem_ready, fp_rs1_busy, fp_rs2_busy;
   logic [4:0]      fp_rd_sel;
   logic [XLEN-1:0] fp_rd_data;

   regfile_wb_arbiter #(.XLEN(XLEN), .FIXED_PRIO(1'b0)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
      .rd_sel(rd_sel), .rd_data(rd_data),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
   );

   regfile_wb_arbiter #(.XLEN(XLEN), .FIXED_PRIO(1'b1)) dut_fp (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(fp_alu_ready),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(fp_mem_ready),
      .rd_sel(fp_rd_sel), .rd_data(fp_rd_data),
      .iss_valid(1'b0), .iss_rd(iss_rd), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
      .rs1_busy(fp_rs1_busy), .rs2_busy(fp_rs2_busy)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: ties alternate starting with ALU, pending writes kept as a queue.
   int              tie_cnt;
   int              pend_q[$];
   logic [4:0]      exp_sel, exp_fp_sel;
   logic [XLEN-1:0] exp_data, exp_fp_data;
   logic            cap_alu_rdy, cap_mem_rdy, cap_fp_alu_rdy, cap_fp_mem_rdy;
   logic            cap_rs1_busy, cap_rs2_busy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic bit in_pend(input int r);
      foreach (pend_q[i]) if (pend_q[i] == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [4:0] pick_reg();
      if (pend_q.size() > 0 && $urandom_range(0, 1) == 1)
         return 5'(pend_q[$urandom_range(0, pend_q.size() - 1)]);
      return 5'($urandom_range(0, 31));
   endfunction

   // Check at the falling edge, advance the model, return 1 time unit after the rising edge.
   task automatic cycle();
      logic ea, em, efa, efm, b1, b2;
      @(negedge clk);
      ea  = !reset && alu_valid && (!mem_valid || (tie_cnt % 2) == 0);
      em  = !reset && mem_valid && (!alu_valid || (tie_cnt % 2) == 1);
      efa = !reset && alu_valid;
      efm = !reset && mem_valid && !alu_valid;
      b1  = SB_EN && rs1_sel != 5'd0 && in_pend(int'(rs1_sel));
      b2  = SB_EN && rs2_sel != 5'd0 && in_pend(int'(rs2_sel));
      chk("alu_ready", 32'(alu_ready), 32'(ea));
      chk("mem_ready", 32'(mem_ready), 32'(em));
      chk("fp_alu_ready", 32'(fp_alu_ready), 32'(efa));
      chk("fp_mem_ready", 32'(fp_mem_ready), 32'(efm));
      chk("rs1_busy", 32'(rs1_busy), 32'(b1));
      chk("rs2_busy", 32'(rs2_busy), 32'(b2));
      chk("rd_sel", 32'(rd_sel), 32'(exp_sel));
      chk("rd_data", rd_data, exp_data);
      chk("fp_rd_sel", 32'(fp_rd_sel), 32'(exp_fp_sel));
      chk("fp_rd_data", fp_rd_data, exp_fp_data);
      cap_alu_rdy    = alu_ready;
      cap_mem_rdy    = mem_ready;
      cap_fp_alu_rdy = fp_alu_ready;
      cap_fp_mem_rdy = fp_mem_ready;
      cap_rs1_busy   = rs1_busy;
      cap_rs2_busy   = rs2_busy;
      if (reset) begin
         exp_sel = '0; exp_data = '0; exp_fp_sel = '0; exp_fp_data = '0;
         tie_cnt = 0;
         pend_q.delete();
      end else begin
         exp_sel     = ea  ? alu_rd   : em  ? mem_rd   : 5'd0;
         exp_data    = ea  ? alu_data : em  ? mem_data : '0;
         exp_fp_sel  = efa ? alu_rd   : efm ? mem_rd   : 5'd0;
         exp_fp_data = efa ? alu_data : efm ? mem_data : '0;
         if (alu_valid && mem_valid) tie_cnt++;
         if (ea || em)
            for (int i = pend_q.size() - 1; i >= 0; i--)
               if (pend_q[i] == int'(exp_sel)) pend_q.delete(i);
         if (iss_valid && iss_rd != 5'd0 && !in_pend(int'(iss_rd))) pend_q.push_back(int'(iss_rd));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; alu_valid = 1'b1; mem_valid = 1'b1; iss_valid = 1'b0;
      alu_rd = 5'd3; alu_data = 32'h1111_0003; mem_rd = 5'd7; mem_data = 32'h2222_0007;
      iss_rd = 5'd0; rs1_sel = 5'd0; rs2_sel = 5'd0;
      tie_cnt = 0; exp_sel = '0; exp_data = '0; exp_fp_sel = '0; exp_fp_data = '0;
      cap_alu_rdy = 1'b0; cap_mem_rdy = 1'b0; cap_fp_alu_rdy = 1'b0; cap_fp_mem_rdy = 1'b0;
      cap_rs1_busy = 1'b0; cap_rs2_busy = 1'b0;
      @(posedge clk);
      #1;

      // Reset held two cycles with both requesters valid.
      cycle();
      cycle();
      chk("rst_alu_ready", 32'(cap_alu_rdy), 32'd0);
      chk("rst_mem_ready", 32'(cap_mem_rdy), 32'd0);
      chk("rst_rd_sel", 32'(rd_sel), 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);

      // Four contended cycles after release.
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("rr_alu_grant", 32'(cap_alu_rdy), 32'((i % 2) == 0));
         chk("rr_mem_grant", 32'(cap_mem_rdy), 32'((i % 2) == 1));
         chk("rr_rd_sel", 32'(rd_sel), (i % 2) == 0 ? 32'd3 : 32'd7);
         chk("rr_rd_data", rd_data, (i % 2) == 0 ? 32'h1111_0003 : 32'h2222_0007);
         chk("fp_alu_grant", 32'(cap_fp_alu_rdy), 32'd1);
         chk("fp_mem_grant", 32'(cap_fp_mem_rdy), 32'd0);
         chk("fp_rd_sel", 32'(fp_rd_sel), 32'd3);
      end

      // Single ALU request.
      mem_valid = 1'b0; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      cycle();
      chk("alu_only_ready", 32'(cap_alu_rdy), 32'd1);
      chk("alu_only_rd_sel", 32'(rd_sel), 32'd5);
      chk("alu_only_rd_data", rd_data, 32'hDEADBEEF);
      chk("alu_only_fp_rd_sel", 32'(fp_rd_sel), 32'd5);
      alu_valid = 1'b0;

      // Pending destination 9 released by a MEM write.
      iss_valid = 1'b1; iss_rd = 5'd9; rs1_sel = 5'd9; rs2_sel = 5'd0;
      cycle();
      iss_valid = 1'b0;
      cycle();
      chk("sb_busy_held", 32'(cap_rs1_busy), 32'(SB_EN));
      chk("sb_rs2_zero", 32'(cap_rs2_busy), 32'd0);
      mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h0000_0099;
      cycle();
      chk("sb_mem_ready", 32'(cap_mem_rdy), 32'd1);
      chk("sb_busy_on_xfer", 32'(cap_rs1_busy), 32'(SB_EN));
      chk("sb_wr_rd_sel", 32'(rd_sel), 32'd9);
      chk("sb_busy_cleared", 32'(rs1_busy), 32'd0);
      chk("sb_rs2_zero_wr", 32'(rs2_busy), 32'd0);
      mem_valid = 1'b0;

      // Issue and write of the same register on one edge: issue wins.
      alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h0000_0044;
      iss_valid = 1'b1; iss_rd = 5'd4; rs1_sel = 5'd4;
      cycle();
      chk("sb_same_edge_rd_sel", 32'(rd_sel), 32'd4);
      chk("sb_same_edge_busy", 32'(rs1_busy), 32'(SB_EN));
      alu_valid = 1'b0; iss_valid = 1'b0;
      cycle();
      chk("sb_same_edge_stays", 32'(cap_rs1_busy), 32'(SB_EN));

      // Random traffic; requesters hold their request until accepted.
      for (int n = 0; n < 400; n++) begin
         reset = ($urandom_range(0, 39) == 0);
         if (!(alu_valid && !cap_alu_rdy)) begin
            alu_valid = ($urandom_range(0, 3) != 0);
            alu_rd    = pick_reg();
            alu_data  = $urandom;
         end
         if (!(mem_valid && !cap_mem_rdy)) begin
            mem_valid = ($urandom_range(0, 3) != 0);
            mem_rd    = pick_reg();
            mem_data  = $urandom;
         end
         iss_rd    = 5'($urandom_range(0, 31));
         iss_valid = ($urandom_range(0, 1) == 1) && !in_pend(int'(iss_rd));
         rs1_sel   = pick_reg();
         rs2_sel   = pick_reg();
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
